reg_file_2r1w: RTL and testbench

- Parametrised two-read/one-write register file. It is the clocked successor to the constant 32-entry read file.
- Storage is writable, read outputs are registered, and a write-to-read bypass is provided.
- A sequenced clear/re-initialise mode, driven by a small FSM, restores the power-on contents.
- Sits between instruction decode and the ALU/mux datapath, and supplies both ALU operands each cycle.

---
 rtl/reg_file_2r1w.sv | 163 ++++++++++++++++
 tb/tb_reg_file_2r1w.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_2r1w.sv
// Two-read/one-write register file with registered reads, write-to-read bypass,
// and an FSM-sequenced sweep that restores the power-on contents.
module reg_file_2r1w #(
   parameter int WIDTH         = 32,
   parameter int AW            = 5,
   parameter int INIT_IDENTITY = 1,
   parameter int ZERO_REG      = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en1,
   input  logic [AW-1:0]    inp1,
   input  logic             rd_en2,
   input  logic [AW-1:0]    inp2,
   input  logic             clr,
   output logic [WIDTH-1:0] zout1,
   output logic [WIDTH-1:0] zout2,
   output logic             valid1,
   output logic             valid2,
   output logic             busy
);

   localparam int DEPTH = 2 ** AW;
   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_CLEAR = 1'b1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [0:0]       state_q, state_d;
   logic [AW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic [WIDTH-1:0] zout1_q, zout1_d, zout2_q, zout2_d;
   logic             valid1_q, valid1_d, valid2_q, valid2_d;
   logic             sweeping_s;
   logic             wr_fire_s;

   function automatic logic [WIDTH-1:0] init_val(input logic [AW-1:0] idx);
      logic [WIDTH-1:0] v;
      if (INIT_IDENTITY != 0) begin
         v = WIDTH'(idx);
      end else begin
         v = '0;
      end
      return v;
   endfunction

   // Priority: hardwired zero, then the sweep write, then the port write, then storage.
   function automatic logic [WIDTH-1:0] read_sel(
      input logic [AW-1:0]    addr,
      input logic [WIDTH-1:0] stored,
      input logic             sweeping,
      input logic [AW-1:0]    sweep_idx,
      input logic             wr_fire,
      input logic [AW-1:0]    waddr,
      input logic [WIDTH-1:0] wdata
   );
      logic [WIDTH-1:0] v;
      if ((ZERO_REG != 0) && (addr == {AW{1'b0}})) begin
         v = '0;
      end else if (sweeping && (addr == sweep_idx)) begin
         v = init_val(addr);
      end else if (wr_fire && (addr == waddr)) begin
         v = wdata;
      end else begin
         v = stored;
      end
      return v;
   endfunction

   assign sweeping_s = (state_q == S_CLEAR);
   assign wr_fire_s  = wr_en && (state_q == S_IDLE) &&
                       !((ZERO_REG != 0) && (wr_addr == {AW{1'b0}}));

   // Sweep FSM and array update.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      mem_d   = mem_q;
      case (state_q)
         S_IDLE: begin
            if (wr_fire_s) begin
               mem_d[wr_addr] = wr_data;
            end else begin
               mem_d[wr_addr] = mem_q[wr_addr];
            end
            if (clr) begin
               state_d = S_CLEAR;
               busy_d  = 1'b1;
               cnt_d   = {AW{1'b0}};
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CLEAR: begin
            mem_d[cnt_q] = init_val(cnt_q);
            if (cnt_q == {AW{1'b1}}) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               cnt_d   = {AW{1'b0}};
            end else begin
               cnt_d = cnt_q + AW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            cnt_d   = {AW{1'b0}};
         end
      endcase
   end

   // Read ports; a disabled port holds its data and drops valid.
   always_comb begin
      valid1_d = rd_en1;
      valid2_d = rd_en2;
      if (rd_en1) begin
         zout1_d = read_sel(inp1, mem_q[inp1], sweeping_s, cnt_q, wr_fire_s, wr_addr, wr_data);
      end else begin
         zout1_d = zout1_q;
      end
      if (rd_en2) begin
         zout2_d = read_sel(inp2, mem_q[inp2], sweeping_s, cnt_q, wr_fire_s, wr_addr, wr_data);
      end else begin
         zout2_d = zout2_q;
      end
   end

   // State registers; reset also aborts any sweep in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= init_val(AW'(i));
         end
         state_q  <= S_IDLE;
         cnt_q    <= {AW{1'b0}};
         busy_q   <= 1'b0;
         zout1_q  <= '0;
         zout2_q  <= '0;
         valid1_q <= 1'b0;
         valid2_q <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         zout1_q  <= zout1_d;
         zout2_q  <= zout2_d;
         valid1_q <= valid1_d;
         valid2_q <= valid2_d;
      end
   end

   assign zout1  = zout1_q;
   assign zout2  = zout2_q;
   assign valid1 = valid1_q;
   assign valid2 = valid2_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench for reg_file_2r1w against an array model of the register contents.
module tb_reg_file_2r1w;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_en = 1'b0;
   logic [4:0]  wr_addr = 5'd0;
   logic [31:0] wr_data = 32'd0;
   logic        rd_en1 = 1'b0;
   logic [4:0]  inp1 = 5'd0;
   logic        rd_en2 = 1'b0;
   logic [4:0]  inp2 = 5'd0;
   logic        clr = 1'b0;
   logic [31:0] zout1, zout2;
   logic        valid1, valid2, busy;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] model [32];

   reg_file_2r1w #(.WIDTH(32), .AW(5), .INIT_IDENTITY(1), .ZERO_REG(1)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en1(rd_en1), .inp1(inp1), .rd_en2(rd_en2), .inp2(inp2), .clr(clr),
      .zout1(zout1), .zout2(zout2), .valid1(valid1), .valid2(valid2), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_init();
      for (int i = 0; i < 32; i++) model[i] = 32'(i);
   endtask

   // Expected read value in IDLE: entry 0 is zero, a same-cycle write is seen.
   function automatic logic [31:0] exp_read(input int a, input bit we, input int wa,
                                            input logic [31:0] wd);
      if (a == 0) return 32'd0;
      if (we && wa == a) return wd;
      return model[a];
   endfunction

   task automatic do_write(input int a, input logic [31:0] d);
      wr_en = 1'b1; wr_addr = 5'(a); wr_data = d;
      step();
      wr_en = 1'b0;
      if (a != 0) model[a] = d;
   endtask

   task automatic test_reset();
      #1;
      n_tests++;
      if (zout1 !== 32'd0 || zout2 !== 32'd0 || valid1 !== 1'b0 || valid2 !== 1'b0 || busy !== 1'b0) begin
         $display("FAIL reset_outputs got z1=%h z2=%h v=%b%b busy=%b want zeros", zout1, zout2, valid1, valid2, busy);
         n_fail++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_init();
      rd_en1 = 1'b1; inp1 = 5'd7; rd_en2 = 1'b1; inp2 = 5'd31;
      step();
      rd_en1 = 1'b0; rd_en2 = 1'b0;
      n_tests++;
      if (zout1 !== 32'd7 || zout2 !== 32'd31 || valid1 !== 1'b1 || valid2 !== 1'b1) begin
         $display("FAIL reset_identity got z1=%h z2=%h v=%b%b want 7 31 11", zout1, zout2, valid1, valid2);
         n_fail++;
      end
   endtask

   task automatic test_write_read();
      do_write(5, 32'hDEADBEEF);
      rd_en1 = 1'b1; inp1 = 5'd5;
      step();
      rd_en1 = 1'b0;
      n_tests++;
      if (zout1 !== 32'hDEADBEEF) begin
         $display("FAIL write_read got %h want deadbeef", zout1);
         n_fail++;
      end
      do_write(0, 32'h1234);
      rd_en2 = 1'b1; inp2 = 5'd0;
      step();
      rd_en2 = 1'b0;
      n_tests++;
      if (zout2 !== 32'd0 || valid2 !== 1'b1) begin
         $display("FAIL zero_reg got %h v=%b want 0 v=1", zout2, valid2);
         n_fail++;
      end
   endtask

   task automatic test_bypass();
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5A5A5;
      rd_en1 = 1'b1; inp1 = 5'd9; rd_en2 = 1'b1; inp2 = 5'd9;
      step();
      wr_en = 1'b0; rd_en1 = 1'b0; rd_en2 = 1'b0;
      model[9] = 32'hA5A5A5A5;
      n_tests++;
      if (zout1 !== 32'hA5A5A5A5 || zout2 !== 32'hA5A5A5A5) begin
         $display("FAIL bypass_dual got z1=%h z2=%h want a5a5a5a5", zout1, zout2);
         n_fail++;
      end
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF0000;
      rd_en1 = 1'b1; inp1 = 5'd0;
      step();
      wr_en = 1'b0; rd_en1 = 1'b0;
      n_tests++;
      if (zout1 !== 32'd0) begin
         $display("FAIL bypass_zero got %h want 0", zout1);
         n_fail++;
      end
   endtask

   task automatic test_clear_sweep();
      int cyc;
      do_write(3, 32'hFFFFFFFF);
      do_write(10, 32'hFFFFFFFF);
      do_write(20, 32'hFFFFFFFF);
      clr = 1'b1;
      step();
      clr = 1'b0;
      cyc = 0;
      while (busy === 1'b1 && cyc < 100) begin
         rd_en1 = (cyc == 10);
         inp1 = 5'd20;
         rd_en2 = (cyc == 10 || cyc == 15);
         inp2 = (cyc == 10) ? 5'd10 : 5'd3;
         clr = (cyc == 5);
         wr_en = 1'b1; wr_addr = 5'd25; wr_data = 32'h55;
         step();
         if (cyc == 10) begin
            n_tests++;
            if (zout1 !== 32'hFFFFFFFF || zout2 !== 32'd10 || valid1 !== 1'b1) begin
               $display("FAIL sweep_mid got z1=%h z2=%h v1=%b want ffffffff 0000000a 1", zout1, zout2, valid1);
               n_fail++;
            end
         end
         if (cyc == 15) begin
            n_tests++;
            if (zout2 !== 32'd3) begin
               $display("FAIL sweep_swept got %h want 3", zout2);
               n_fail++;
            end
         end
         cyc++;
      end
      wr_en = 1'b0; rd_en1 = 1'b0; rd_en2 = 1'b0; clr = 1'b0;
      model_init();
      n_tests++;
      if (cyc != 32) begin
         $display("FAIL busy_len got %0d cycles want 32", cyc);
         n_fail++;
      end
      rd_en1 = 1'b1; inp1 = 5'd3; rd_en2 = 1'b1; inp2 = 5'd20;
      step();
      n_tests++;
      if (zout1 !== 32'd3 || zout2 !== 32'd20) begin
         $display("FAIL sweep_done got z1=%h z2=%h want 3 20", zout1, zout2);
         n_fail++;
      end
      inp1 = 5'd10; inp2 = 5'd25;
      step();
      rd_en1 = 1'b0; rd_en2 = 1'b0;
      n_tests++;
      if (zout1 !== 32'd10 || zout2 !== 32'd25 || busy !== 1'b0) begin
         $display("FAIL sweep_wr_ignored got z1=%h z2=%h busy=%b want 10 25 0", zout1, zout2, busy);
         n_fail++;
      end
   endtask

   task automatic test_reset_mid_sweep();
      do_write(30, 32'hFFFFFFFF);
      clr = 1'b1;
      step();
      clr = 1'b0;
      rd_en1 = 1'b1; inp1 = 5'd30; rd_en2 = 1'b1; inp2 = 5'd31;
      for (int i = 0; i < 12; i++) step();
      n_tests++;
      if (busy !== 1'b1 || zout1 !== 32'hFFFFFFFF || zout2 !== 32'd31) begin
         $display("FAIL pre_abort got busy=%b z1=%h z2=%h want 1 ffffffff 1f", busy, zout1, zout2);
         n_fail++;
      end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (busy !== 1'b0 || zout1 !== 32'd0 || zout2 !== 32'd0 || valid1 !== 1'b0 || valid2 !== 1'b0) begin
         $display("FAIL abort got busy=%b z1=%h z2=%h v=%b%b want all 0", busy, zout1, zout2, valid1, valid2);
         n_fail++;
      end
      rd_en1 = 1'b0; rd_en2 = 1'b0;
      step();
      rst_n = 1'b1;
      model_init();
      rd_en1 = 1'b1; inp1 = 5'd30; rd_en2 = 1'b1; inp2 = 5'd12;
      step();
      step();
      rd_en1 = 1'b0; rd_en2 = 1'b0;
      n_tests++;
      if (zout1 !== 32'd30 || zout2 !== 32'd12 || busy !== 1'b0) begin
         $display("FAIL post_abort got z1=%h z2=%h busy=%b want 30 12 0", zout1, zout2, busy);
         n_fail++;
      end
   endtask

   task automatic test_hold();
      do_write(4, 32'h11);
      rd_en1 = 1'b1; inp1 = 5'd4;
      step();
      n_tests++;
      if (zout1 !== 32'h11 || valid1 !== 1'b1) begin
         $display("FAIL hold_read got %h v=%b want 11 1", zout1, valid1);
         n_fail++;
      end
      rd_en1 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         inp1 = 5'($urandom_range(31, 0));
         step();
         n_tests++;
         if (zout1 !== 32'h11 || valid1 !== 1'b0) begin
            $display("FAIL hold_%0d got %h v=%b want 11 0", i, zout1, valid1);
            n_fail++;
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] e1, e2, wd;
      bit we, r1, r2;
      int wa, a1, a2;
      e1 = zout1; e2 = zout2;
      for (int i = 0; i < 300; i++) begin
         we = 1'($urandom_range(1, 0));
         wa = $urandom_range(31, 0);
         wd = $urandom;
         r1 = 1'($urandom_range(1, 0));
         r2 = 1'($urandom_range(1, 0));
         a1 = (i % 4 == 0) ? wa : $urandom_range(31, 0);
         a2 = (i % 5 == 0) ? a1 : $urandom_range(31, 0);
         wr_en = we; wr_addr = 5'(wa); wr_data = wd;
         rd_en1 = r1; inp1 = 5'(a1); rd_en2 = r2; inp2 = 5'(a2);
         if (r1) e1 = exp_read(a1, we, wa, wd);
         if (r2) e2 = exp_read(a2, we, wa, wd);
         step();
         if (we && wa != 0) model[wa] = wd;
         n_tests++;
         if (zout1 !== e1 || zout2 !== e2 || valid1 !== r1 || valid2 !== r2) begin
            $display("FAIL random_%0d got z1=%h z2=%h v=%b%b want %h %h %b%b",
                     i, zout1, zout2, valid1, valid2, e1, e2, r1, r2);
            n_fail++;
         end
      end
      wr_en = 1'b0; rd_en1 = 1'b0; rd_en2 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_bypass();
      test_clear_sweep();
      test_reset_mid_sweep();
      test_hold();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
